j1_boot_memsys: RTL and testbench

- Responder side of the j1 core's memory interface: one word-addressed dual-port RAM serves the core's instruction-fetch port (A) and data port (B), plus a small memory-mapped IO window.
- Holds the core in reset while a byte-stream boot loader fills RAM from address 0, then releases it.
- Sits between the j1 core, the host byte link (UART receiver) and IO peripherals.

---
 rtl/j1_boot_memsys_if.sv | 54 +++++
 rtl/j1_boot_memsys.sv | 199 +++++++++++++++++++
 tb/tb_j1_boot_memsys.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_boot_memsys_if.sv
// -----------------------------------------------------------------------------
// j1_boot_memsys_if
// Bundles every non-clock signal of j1_boot_memsys: the j1 core's fetch and data
// ports, the boot-loader byte link and the IO window.
//
//   master : drives core/loader/IO-side inputs of the memory system
//   slave  : the memory system itself (j1_boot_memsys)
//
//   code_addr  AW   instruction fetch word address
//   insn       16   registered instruction word
//   mem_addr   AW   data word address
//   mem_wr     1    data write strobe
//   dout       16   core write data
//   din        16   registered core read data
//   ld_byte    8    loader byte
//   ld_valid   1    loader byte valid
//   ld_ready   1    loader byte accepted when ld_valid & ld_ready
//   cpu_reset  1    active-high reset to the j1 core
//   io_addr    AW   offset of mem_addr above the IO base (full width so that
//                   every address in the IO window maps to a distinct offset)
//   io_wr      1    IO write pulse
//   io_wdata   16   IO write data
//   io_rdata   16   IO read data, sampled in the address cycle
//   load_err   1    boot checksum failure
// -----------------------------------------------------------------------------
interface j1_boot_memsys_if #(
   parameter int AW = 14
);
   logic [AW-1:0] code_addr;
   logic [15:0]   insn;
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [15:0]   dout;
   logic [15:0]   din;
   logic [7:0]    ld_byte;
   logic          ld_valid;
   logic          ld_ready;
   logic          cpu_reset;
   logic [AW-1:0] io_addr;
   logic          io_wr;
   logic [15:0]   io_wdata;
   logic [15:0]   io_rdata;
   logic          load_err;

   modport master (
      output code_addr, mem_addr, mem_wr, dout, ld_byte, ld_valid, io_rdata,
      input  insn, din, ld_ready, cpu_reset, io_addr, io_wr, io_wdata, load_err
   );

   modport slave (
      input  code_addr, mem_addr, mem_wr, dout, ld_byte, ld_valid, io_rdata,
      output insn, din, ld_ready, cpu_reset, io_addr, io_wr, io_wdata, load_err
   );
endinterface

// File: rtl/j1_boot_memsys.sv
// -----------------------------------------------------------------------------
// j1_boot_memsys
// Responder side of the j1 core's memory interface. A word-addressed RAM of
// 2^RAM_LOG2 x 16 bits serves instruction fetch (port A) and data access
// (port B); data addresses at or above 2^RAM_LOG2 fall into an IO window.
// After reset the core is held in reset while a little-endian byte stream
// (count word, then data words) is written to RAM from address 0; then the
// core is released and the loader link goes idle until the next reset.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    j1_boot_memsys_if.slave (core ports, loader link, IO window)
//
// Build option:
//   J1_BOOT_CHECKSUM_EN  - when defined, a 16-bit little-endian checksum
//                          (mod-2^16 sum of all data words) follows the data;
//                          a mismatch parks the loader in ERROR with load_err
//                          set and the core held in reset.
// -----------------------------------------------------------------------------
module j1_boot_memsys #(
   parameter int RAM_LOG2 = 13,
   parameter int AW       = 14
) (
   input  logic             clk,
   input  logic             reset,
   j1_boot_memsys_if.slave  bus
);

   localparam int RAM_DEPTH = 1 << RAM_LOG2;

   typedef enum logic [2:0] {
      S_CNT_LO,
      S_CNT_HI,
      S_DAT_LO,
      S_DAT_HI,
      S_CK_LO,
      S_CK_HI,
      S_RUN,
      S_ERROR
   } state_t;

`ifdef J1_BOOT_CHECKSUM_EN
   localparam state_t S_AFTER_DATA = S_CK_LO;
`else
   localparam state_t S_AFTER_DATA = S_RUN;
`endif

   // ---------------------------------------------------------------- state
   state_t         r_state;
   logic           r_ld_ready;
   logic           r_cpu_reset;
   logic [15:0]    r_wcnt;      // words received; also the RAM write pointer
   logic [7:0]     r_lo;        // low byte waiting for its high byte
   logic [15:0]    r_n;         // word count of the stream
`ifdef J1_BOOT_CHECKSUM_EN
   logic [15:0]    r_sum;
   logic           r_load_err;
`endif

   logic [15:0]    r_mem [RAM_DEPTH];
   logic [15:0]    r_insn;
   logic [15:0]    r_ramb;      // port B RAM read data
   logic [15:0]    r_io_q;      // io_rdata captured in the address cycle
   logic           r_sel_io;    // previous port B access was to IO
   logic           r_b_run;     // previous port B access happened in RUN

   // ---------------------------------------------------------------- decode
   logic               w_run;
   logic               w_acc;
   logic [15:0]        w_ld_word;
   logic               w_is_io;
   logic               w_in_ram;
   logic               w_last;
   logic               w_core_we;
   logic               w_ld_we;
   logic               w_we;
   logic [RAM_LOG2-1:0] w_waddr;
   logic [15:0]        w_wdata;
   logic               w_unused;

   assign w_run     = (r_state == S_RUN);
   assign w_acc     = bus.ld_valid & r_ld_ready;
   assign w_ld_word = {bus.ld_byte, r_lo};
   assign w_is_io   = (bus.mem_addr[AW-1:RAM_LOG2] != '0);
   // Words past the end of RAM are consumed but dropped rather than wrapped.
   assign w_in_ram  = ({16'd0, r_wcnt} < 32'(RAM_DEPTH));
   assign w_last    = (r_wcnt == (r_n - 16'd1));

   // Loader and core never write in the same state, so one write port serves both.
   assign w_core_we = w_run & bus.mem_wr & ~w_is_io;
   assign w_ld_we   = w_acc & (r_state == S_DAT_HI) & w_in_ram;
   assign w_we      = w_core_we | w_ld_we;
   assign w_waddr   = w_run ? bus.mem_addr[RAM_LOG2-1:0] : r_wcnt[RAM_LOG2-1:0];
   assign w_wdata   = w_run ? bus.dout : w_ld_word;

   // Fetch addresses wrap modulo the RAM size; the upper bits are ignored.
   assign w_unused  = &{1'b0, bus.code_addr[AW-1:RAM_LOG2]};

   // ---------------------------------------------------------------- loader FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_CNT_LO;
         r_ld_ready  <= 1'b0;
         r_cpu_reset <= 1'b1;
         r_wcnt      <= '0;
`ifdef J1_BOOT_CHECKSUM_EN
         r_sum       <= '0;
         r_load_err  <= 1'b0;
`endif
      end else begin
         r_cpu_reset <= ~w_run;
         r_ld_ready  <= (r_state != S_RUN) && (r_state != S_ERROR);
         if (w_acc) begin
            case (r_state)
               S_CNT_LO: r_state <= S_CNT_HI;
               S_CNT_HI: begin
                  if (w_ld_word == 16'd0) begin
                     r_state    <= S_AFTER_DATA;
                     r_ld_ready <= (S_AFTER_DATA != S_RUN);
                  end else begin
                     r_state <= S_DAT_LO;
                  end
               end
               S_DAT_LO: r_state <= S_DAT_HI;
               S_DAT_HI: begin
                  r_wcnt <= r_wcnt + 16'd1;
`ifdef J1_BOOT_CHECKSUM_EN
                  r_sum  <= r_sum + w_ld_word;
`endif
                  if (w_last) begin
                     r_state    <= S_AFTER_DATA;
                     r_ld_ready <= (S_AFTER_DATA != S_RUN);
                  end else begin
                     r_state <= S_DAT_LO;
                  end
               end
`ifdef J1_BOOT_CHECKSUM_EN
               S_CK_LO: r_state <= S_CK_HI;
               S_CK_HI: begin
                  r_ld_ready <= 1'b0;
                  if (w_ld_word == r_sum) begin
                     r_state <= S_RUN;
                  end else begin
                     r_state    <= S_ERROR;
                     r_load_err <= 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   // Byte holding registers carry data only and need no reset.
   always_ff @(posedge clk) begin
      if (w_acc && (r_state == S_CNT_LO || r_state == S_DAT_LO || r_state == S_CK_LO))
         r_lo <= bus.ld_byte;
      if (w_acc && r_state == S_CNT_HI)
         r_n <= w_ld_word;
   end

   // ---------------------------------------------------------------- RAM
   // Non-blocking write plus registered reads give read-first behaviour on both ports.
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
      r_ramb <= r_mem[bus.mem_addr[RAM_LOG2-1:0]];
      r_io_q <= bus.io_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_insn   <= '0;
         r_sel_io <= 1'b0;
         r_b_run  <= 1'b0;
      end else begin
         r_insn   <= r_mem[bus.code_addr[RAM_LOG2-1:0]];
         r_sel_io <= w_is_io;
         r_b_run  <= w_run;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.insn      = r_insn;
   assign bus.din       = r_b_run ? (r_sel_io ? r_io_q : r_ramb) : 16'd0;
   assign bus.ld_ready  = r_ld_ready;
   assign bus.cpu_reset = r_cpu_reset;
   assign bus.io_addr   = bus.mem_addr - AW'(RAM_DEPTH);
   assign bus.io_wr     = w_run & bus.mem_wr & w_is_io;
   assign bus.io_wdata  = bus.dout;
`ifdef J1_BOOT_CHECKSUM_EN
   assign bus.load_err  = r_load_err;
`else
   assign bus.load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_j1_boot_memsys.sv
// -----------------------------------------------------------------------------
// tb_j1_boot_memsys
// Self-checking bench for j1_boot_memsys. Read expectations are queued when an
// access is driven and compared one cycle later when insn/din are produced.
// -----------------------------------------------------------------------------
module tb_j1_boot_memsys;

   localparam int AW       = 14;
   localparam int RAM_LOG2 = 13;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   j1_boot_memsys_if #(.AW(AW)) bus ();

   j1_boot_memsys #(.RAM_LOG2(RAM_LOG2), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   string       q_at[$];
   string       q_bt[$];
   logic        a_req  = 1'b0;
   logic        b_req  = 1'b0;
   logic        a_pend = 1'b0;
   logic        b_pend = 1'b0;
   logic [15:0] tb_words[$];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: a read issued in one cycle is compared at the following negedge.
   always @(posedge clk) begin
      a_pend <= a_req;
      b_pend <= b_req;
   end

   always @(negedge clk) begin
      if (a_pend) check(q_at.pop_front(), bus.insn, q_a.pop_front());
      if (b_pend) check(q_bt.pop_front(), bus.din, q_b.pop_front());
   end

   task automatic exp_a(input string tag, input logic [15:0] v);
      q_at.push_back(tag);
      q_a.push_back(v);
      a_req = 1'b1;
   endtask

   task automatic exp_b(input string tag, input logic [15:0] v);
      q_bt.push_back(tag);
      q_b.push_back(v);
      b_req = 1'b1;
   endtask

   task automatic tick();
      @(negedge clk);
      a_req      = 1'b0;
      b_req      = 1'b0;
      bus.mem_wr = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      bus.ld_byte  = b;
      bus.ld_valid = 1'b1;
      while (bus.ld_ready !== 1'b1 && t < 16) begin
         @(negedge clk);
         t++;
      end
      if (bus.ld_ready !== 1'b1) check("ld_ready_timeout", 16'(bus.ld_ready), 16'd1);
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   task automatic load_stream();
      logic [15:0] n;
      logic [15:0] w;
`ifdef J1_BOOT_CHECKSUM_EN
      logic [15:0] sum;
      sum = 16'd0;
`endif
      n = 16'(tb_words.size());
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int i = 0; i < tb_words.size(); i++) begin
         w = tb_words[i];
         send_byte(w[7:0]);
         send_byte(w[15:8]);
`ifdef J1_BOOT_CHECKSUM_EN
         sum = sum + w;
`endif
      end
`ifdef J1_BOOT_CHECKSUM_EN
      send_byte(sum[7:0]);
      send_byte(sum[15:8]);
`endif
   endtask

   function automatic logic [15:0] ovf_word(input int i);
      return 16'(i * 7 + 257);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.code_addr = '0;
      bus.mem_addr = '0;
      bus.mem_wr   = 1'b0;
      bus.dout     = '0;
      bus.ld_byte  = '0;
      bus.ld_valid = 1'b0;
      bus.io_rdata = '0;

      // ---- reset state
      repeat (3) tick();
      check("rst_insn",      bus.insn,             16'h0000);
      check("rst_din",       bus.din,              16'h0000);
      check("rst_ld_ready",  16'(bus.ld_ready),    16'd0);
      check("rst_cpu_reset", 16'(bus.cpu_reset),   16'd1);
      check("rst_io_wr",     16'(bus.io_wr),       16'd0);
      check("rst_load_err",  16'(bus.load_err),    16'd0);
      reset = 1'b0;
      check("ld_ready_first_cycle", 16'(bus.ld_ready), 16'd0);

      // Core activity during load must be ignored.
      bus.mem_addr = 14'h2003;
      bus.mem_wr   = 1'b1;
      bus.dout     = 16'hDEAD;
      @(negedge clk);
      check("ld_ready_second_cycle", 16'(bus.ld_ready), 16'd1);
      check("load_io_wr",  16'(bus.io_wr), 16'd0);
      check("load_din",    bus.din,        16'h0000);
      bus.mem_addr = 14'd0;

      // ---- basic load: 02 00 34 12 CD AB
      tb_words = '{16'h1234, 16'hABCD};
      load_stream();
      bus.mem_wr = 1'b0;
      check("run_ld_ready",     16'(bus.ld_ready),  16'd0);
      check("run_cpu_reset_t0", 16'(bus.cpu_reset), 16'd1);
      tick();
      check("run_cpu_reset_t1", 16'(bus.cpu_reset), 16'd0);

      bus.code_addr = 14'd1;  exp_a("insn_a1", 16'hABCD); tick();
      bus.code_addr = 14'd0;  exp_a("insn_a0", 16'h1234);
      bus.mem_addr  = 14'd0;  exp_b("din_a0_after_load_noise", 16'h1234); tick();

      // ---- port B RAM read-first and A/B collision
      bus.mem_addr = 14'd5; bus.mem_wr = 1'b1; bus.dout = 16'h1111; tick();
      bus.mem_addr = 14'd5; bus.mem_wr = 1'b1; bus.dout = 16'h00FF;
      bus.code_addr = 14'd5;
      exp_b("din_read_first", 16'h1111);
      exp_a("insn_collision_old", 16'h1111);
      tick();
      bus.mem_addr = 14'd5; exp_b("din_after_write", 16'h00FF);
      exp_a("insn_after_write", 16'h00FF);
      tick();
      bus.mem_addr = 14'd3; bus.mem_wr = 1'b1; bus.dout = 16'h3333; tick();

      // ---- IO window
      bus.mem_addr = 14'h2003; bus.mem_wr = 1'b1; bus.dout = 16'hBEEF;
      bus.io_rdata = 16'h5A5A;
      #1;
      check("io_wr_pulse", 16'(bus.io_wr),   16'd1);
      check("io_addr",     16'(bus.io_addr), 16'd3);
      check("io_wdata",    bus.io_wdata,     16'hBEEF);
      exp_b("din_io_5a5a", 16'h5A5A);
      tick();
      bus.mem_addr = 14'h2003; bus.io_rdata = 16'h1357;
      #1;
      check("io_wr_read", 16'(bus.io_wr), 16'd0);
      exp_b("din_io_1357", 16'h1357);
      tick();
      bus.mem_addr = 14'd3; bus.code_addr = 14'd3;
      exp_b("din_ram3_untouched", 16'h3333);
      exp_a("insn_ram3_untouched", 16'h3333);
      tick();

      // ---- empty stream: 00 00
      apply_reset();
      tb_words.delete();
      load_stream();
      check("empty_ld_ready",     16'(bus.ld_ready),  16'd0);
      check("empty_cpu_reset_t0", 16'(bus.cpu_reset), 16'd1);
      tick();
      check("empty_cpu_reset_t1", 16'(bus.cpu_reset), 16'd0);
      check("empty_ld_ready_t1",  16'(bus.ld_ready),  16'd0);
      bus.code_addr = 14'd1; exp_a("empty_ram_kept", 16'hABCD); tick();

      // ---- reset in the middle of a load
      apply_reset();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      reset = 1'b1;
      tick();
      check("abort_cpu_reset", 16'(bus.cpu_reset), 16'd1);
      check("abort_ld_ready",  16'(bus.ld_ready),  16'd0);
      tick();
      reset = 1'b0;
      tb_words = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
      load_stream();
      tick();
      check("reload_cpu_reset", 16'(bus.cpu_reset), 16'd0);
      bus.code_addr = 14'd0; exp_a("reload_w0", 16'hA1B2); tick();
      bus.code_addr = 14'd1; exp_a("reload_w1", 16'hC3D4); tick();
      bus.code_addr = 14'd2; exp_a("reload_w2", 16'hE5F6); tick();

      // ---- overflow: two words beyond the end of RAM are dropped
      apply_reset();
      tb_words.delete();
      for (int i = 0; i < (1 << RAM_LOG2) + 2; i++) tb_words.push_back(ovf_word(i));
      load_stream();
      tick();
      check("ovf_cpu_reset", 16'(bus.cpu_reset), 16'd0);
      bus.code_addr = 14'd0;    exp_a("ovf_w0_no_wrap", ovf_word(0));    tick();
      bus.code_addr = 14'd1;    exp_a("ovf_w1_no_wrap", ovf_word(1));    tick();
      bus.code_addr = 14'd8191; exp_a("ovf_w_last",     ovf_word(8191)); tick();
      bus.code_addr = 14'd8192; exp_a("fetch_mod_wrap", ovf_word(0));
      bus.mem_addr  = 14'd8191; exp_b("ovf_din_last",   ovf_word(8191)); tick();

`ifdef J1_BOOT_CHECKSUM_EN
      // ---- checksum mismatch then match
      apply_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      check("ck_bad_load_err", 16'(bus.load_err), 16'd1);
      check("ck_bad_ld_ready", 16'(bus.ld_ready), 16'd0);
      tick();
      check("ck_bad_cpu_reset", 16'(bus.cpu_reset), 16'd1);
      check("ck_bad_err_held",  16'(bus.load_err),  16'd1);
      apply_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h00);
      tick();
      check("ck_good_cpu_reset", 16'(bus.cpu_reset), 16'd0);
      check("ck_good_load_err",  16'(bus.load_err),  16'd0);
`endif

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
